// File: rtl/issue_queue.sv
// In-order dual-issue queue between decode and register read: buffers decoded pairs and steers up to two oldest entries onto lanes 0/1.
// Optional ISSUE_PERF_EN macro adds a 32-bit counter of pairs split by a dependency or lane conflict.

`ifndef ISSUE_QUEUE_CTRL_DEFS
`define ISSUE_QUEUE_CTRL_DEFS
`define CTRL_BUS 19:0
`define CTRL_RD 4:0
`define CTRL_RS1 9:5
`define CTRL_RS2 14:10
`define CTRL_REGWRITE 15
`define CTRL_RS1_ACTIVE 16
`define CTRL_RS2_ACTIVE 17
`define CTRL_ISSUE_PRI 18
`define CTRL_ISSUE_SLOT 19
`endif

module issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic                      flush_i,
    input  logic                      enq0_valid_i,
    input  logic                      enq1_valid_i,
    input  logic [31:0]               enq0_inst_i,
    input  logic [31:0]               enq1_inst_i,
    input  logic [`CTRL_BUS]          enq0_ctrl_i,
    input  logic [`CTRL_BUS]          enq1_ctrl_i,
    output logic                      enq_ready_o,
    output logic                      iss0_valid_o,
    output logic                      iss1_valid_o,
    output logic [31:0]               iss0_inst_o,
    output logic [31:0]               iss1_inst_o,
    output logic [`CTRL_BUS]          iss0_ctrl_o,
    output logic [`CTRL_BUS]          iss1_ctrl_o,
    output logic                      iss_swap_o,
    input  logic                      iss_ready_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [31:0]               split_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      inst_q [DEPTH];
    logic [`CTRL_BUS] ctrl_q [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [PW-1:0]    h1Idx, tailPlus1;
    logic [31:0]      h0Inst, h1Inst;
    logic [`CTRL_BUS] h0Ctrl, h1Ctrl;
    logic             h0Present, h1Present;
    logic             dep, conflict, pair, swapPair;
    logic             h0Pin0, h0Pin1, h1Pin0, h1Pin1;
    logic             enqFire;
    logic [1:0]       enqN, deqCnt, deqN;

    assign h1Idx     = head_q + PW'(1);
    assign tailPlus1 = tail_q + PW'(1);
    assign h0Inst    = inst_q[head_q];
    assign h0Ctrl    = ctrl_q[head_q];
    assign h1Inst    = inst_q[h1Idx];
    assign h1Ctrl    = ctrl_q[h1Idx];
    assign h0Present = (count_q != '0);
    assign h1Present = (count_q >= CW'(2));

    assign h0Pin0 = h0Ctrl[`CTRL_ISSUE_PRI] && !h0Ctrl[`CTRL_ISSUE_SLOT];
    assign h0Pin1 = h0Ctrl[`CTRL_ISSUE_PRI] &&  h0Ctrl[`CTRL_ISSUE_SLOT];
    assign h1Pin0 = h1Ctrl[`CTRL_ISSUE_PRI] && !h1Ctrl[`CTRL_ISSUE_SLOT];
    assign h1Pin1 = h1Ctrl[`CTRL_ISSUE_PRI] &&  h1Ctrl[`CTRL_ISSUE_SLOT];

    // Younger reads a register the older one writes: it must wait a cycle.
    assign dep = h0Ctrl[`CTRL_REGWRITE] && (h0Ctrl[`CTRL_RD] != 5'd0) &&
                 (((h1Ctrl[`CTRL_RS1] == h0Ctrl[`CTRL_RD]) && h1Ctrl[`CTRL_RS1_ACTIVE]) ||
                  ((h1Ctrl[`CTRL_RS2] == h0Ctrl[`CTRL_RD]) && h1Ctrl[`CTRL_RS2_ACTIVE]));

    assign conflict = (h0Pin0 && h1Pin0) || (h0Pin1 && h1Pin1);
    assign pair     = h1Present && !dep && !conflict;
    assign swapPair = h0Pin1 || h1Pin0;

    always_comb begin
        iss0_valid_o = 1'b0;
        iss1_valid_o = 1'b0;
        iss0_inst_o  = '0;
        iss1_inst_o  = '0;
        iss0_ctrl_o  = '0;
        iss1_ctrl_o  = '0;
        iss_swap_o   = 1'b0;
        deqCnt       = 2'd0;
        if (pair) begin
            iss0_valid_o = 1'b1;
            iss1_valid_o = 1'b1;
            deqCnt       = 2'd2;
            if (swapPair) begin
                iss0_inst_o = h1Inst;
                iss0_ctrl_o = h1Ctrl;
                iss1_inst_o = h0Inst;
                iss1_ctrl_o = h0Ctrl;
                iss_swap_o  = 1'b1;
            end else begin
                iss0_inst_o = h0Inst;
                iss0_ctrl_o = h0Ctrl;
                iss1_inst_o = h1Inst;
                iss1_ctrl_o = h1Ctrl;
            end
        end else if (h0Present) begin
            deqCnt = 2'd1;
            if (h0Pin1) begin
                iss1_valid_o = 1'b1;
                iss1_inst_o  = h0Inst;
                iss1_ctrl_o  = h0Ctrl;
                iss_swap_o   = 1'b1;
            end else begin
                iss0_valid_o = 1'b1;
                iss0_inst_o  = h0Inst;
                iss0_ctrl_o  = h0Ctrl;
            end
        end
    end

    assign enq_ready_o = (CW'(DEPTH) - count_q) >= CW'(2);
    assign enqFire     = enq0_valid_i && enq_ready_o;
    assign enqN        = !enqFire ? 2'd0 : (enq1_valid_i ? 2'd2 : 2'd1);
    assign deqN        = iss_ready_i ? deqCnt : 2'd0;
    assign count_o     = count_q;

    always_comb begin
        head_d  = head_q + PW'(deqN);
        tail_d  = tail_q + PW'(enqN);
        count_d = count_q + CW'(enqN) - CW'(deqN);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is governed entirely by count_q.
    always_ff @(posedge clock_i) begin
        if (enqFire) begin
            inst_q[tail_q] <= enq0_inst_i;
            ctrl_q[tail_q] <= enq0_ctrl_i;
            if (enq1_valid_i) begin
                inst_q[tailPlus1] <= enq1_inst_i;
                ctrl_q[tailPlus1] <= enq1_ctrl_i;
            end
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] splitCnt_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            splitCnt_q <= '0;
        end else if (h1Present && iss_ready_i && (dep || conflict)) begin
            splitCnt_q <= splitCnt_q + 32'd1;
        end
    end

    assign split_cnt_o = splitCnt_q;
`else
    assign split_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios then randomized traffic, compared against a queue-based reference model.

`ifndef ISSUE_QUEUE_CTRL_DEFS
`define ISSUE_QUEUE_CTRL_DEFS
`define CTRL_BUS 19:0
`define CTRL_RD 4:0
`define CTRL_RS1 9:5
`define CTRL_RS2 14:10
`define CTRL_REGWRITE 15
`define CTRL_RS1_ACTIVE 16
`define CTRL_RS2_ACTIVE 17
`define CTRL_ISSUE_PRI 18
`define CTRL_ISSUE_SLOT 19
`endif

module tb_issue_queue;

    localparam int DEPTH = 8;

    logic             clock_i = 1'b0;
    logic             reset_ni;
    logic             flush_i;
    logic             enq0_valid_i, enq1_valid_i;
    logic [31:0]      enq0_inst_i, enq1_inst_i;
    logic [`CTRL_BUS] enq0_ctrl_i, enq1_ctrl_i;
    logic             enq_ready_o;
    logic             iss0_valid_o, iss1_valid_o;
    logic [31:0]      iss0_inst_o, iss1_inst_o;
    logic [`CTRL_BUS] iss0_ctrl_o, iss1_ctrl_o;
    logic             iss_swap_o;
    logic             iss_ready_i;
    logic [3:0]       count_o;
    logic [31:0]      split_cnt_o;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .enq0_valid_i(enq0_valid_i), .enq1_valid_i(enq1_valid_i),
        .enq0_inst_i(enq0_inst_i), .enq1_inst_i(enq1_inst_i),
        .enq0_ctrl_i(enq0_ctrl_i), .enq1_ctrl_i(enq1_ctrl_i),
        .enq_ready_o(enq_ready_o),
        .iss0_valid_o(iss0_valid_o), .iss1_valid_o(iss1_valid_o),
        .iss0_inst_o(iss0_inst_o), .iss1_inst_o(iss1_inst_o),
        .iss0_ctrl_o(iss0_ctrl_o), .iss1_ctrl_o(iss1_ctrl_o),
        .iss_swap_o(iss_swap_o), .iss_ready_i(iss_ready_i),
        .count_o(count_o), .split_cnt_o(split_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [31:0] inst;
        logic [19:0] ctrl;
    } entry_t;

    typedef struct packed {
        logic        v0, v1, swap, splitEv;
        logic [31:0] i0, i1;
        logic [19:0] c0, c1;
        logic [1:0]  deq;
    } issue_t;

    entry_t      model[$];
    int unsigned splitExp = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [19:0] mkCtrl(input int rd, input int rs1, input int rs2,
                                           input bit rw, input bit a1, input bit a2,
                                           input bit pri, input bit slot);
        logic [19:0] c;
        logic [4:0]  r;
        c = '0;
        r = rd[4:0];  c[`CTRL_RD]  = r;
        r = rs1[4:0]; c[`CTRL_RS1] = r;
        r = rs2[4:0]; c[`CTRL_RS2] = r;
        c[`CTRL_REGWRITE]   = rw;
        c[`CTRL_RS1_ACTIVE] = a1;
        c[`CTRL_RS2_ACTIVE] = a2;
        c[`CTRL_ISSUE_PRI]  = pri;
        c[`CTRL_ISSUE_SLOT] = slot;
        return c;
    endfunction

    function automatic bit pinnedTo(input logic [19:0] c, input bit s);
        return c[`CTRL_ISSUE_PRI] && (c[`CTRL_ISSUE_SLOT] == s);
    endfunction

    // Issue decision derived from the oldest two entries of the model queue.
    function automatic issue_t predict();
        issue_t p;
        entry_t a, b;
        bit dep, conflict;
        p = '0;
        if (model.size() == 0) return p;
        a = model[0];
        if (model.size() >= 2) begin
            b = model[1];
            dep = a.ctrl[`CTRL_REGWRITE] && (a.ctrl[`CTRL_RD] != 0) &&
                  ((b.ctrl[`CTRL_RS1] == a.ctrl[`CTRL_RD] && b.ctrl[`CTRL_RS1_ACTIVE]) ||
                   (b.ctrl[`CTRL_RS2] == a.ctrl[`CTRL_RD] && b.ctrl[`CTRL_RS2_ACTIVE]));
            conflict = (pinnedTo(a.ctrl, 0) && pinnedTo(b.ctrl, 0)) ||
                       (pinnedTo(a.ctrl, 1) && pinnedTo(b.ctrl, 1));
            if (!dep && !conflict) begin
                p.v0 = 1; p.v1 = 1; p.deq = 2;
                if (pinnedTo(a.ctrl, 1) || pinnedTo(b.ctrl, 0)) begin
                    p.swap = 1; p.i0 = b.inst; p.c0 = b.ctrl; p.i1 = a.inst; p.c1 = a.ctrl;
                end else begin
                    p.i0 = a.inst; p.c0 = a.ctrl; p.i1 = b.inst; p.c1 = b.ctrl;
                end
                return p;
            end
            p.splitEv = 1;
        end
        p.deq = 1;
        if (pinnedTo(a.ctrl, 1)) begin
            p.v1 = 1; p.i1 = a.inst; p.c1 = a.ctrl; p.swap = 1;
        end else begin
            p.v0 = 1; p.i0 = a.inst; p.c0 = a.ctrl;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expSplit();
`ifdef ISSUE_PERF_EN
        return splitExp;
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutput();
        issue_t p;
        p = predict();
        chk("iss0_valid", iss0_valid_o, p.v0);
        chk("iss1_valid", iss1_valid_o, p.v1);
        chk("iss0_inst", iss0_inst_o, p.i0);
        chk("iss1_inst", iss1_inst_o, p.i1);
        chk("iss0_ctrl", iss0_ctrl_o, p.c0);
        chk("iss1_ctrl", iss1_ctrl_o, p.c1);
        chk("iss_swap", iss_swap_o, p.swap);
        chk("count", count_o, model.size());
        chk("enq_ready", enq_ready_o, (DEPTH - model.size()) >= 2);
        chk("split_cnt", split_cnt_o, expSplit());
    endtask

    // Drives one cycle of inputs (called just after a falling edge), checks, clocks, updates model.
    task automatic applyStimulus(input bit e0v, input logic [31:0] e0i, input logic [19:0] e0c,
                                 input bit e1v, input logic [31:0] e1i, input logic [19:0] e1c,
                                 input bit rdy, input bit fl);
        issue_t p;
        int sz;
        enq0_valid_i = e0v; enq0_inst_i = e0i; enq0_ctrl_i = e0c;
        enq1_valid_i = e1v; enq1_inst_i = e1i; enq1_ctrl_i = e1c;
        iss_ready_i = rdy; flush_i = fl;
        #1;
        checkOutput();
        p = predict();
        @(posedge clock_i);
        sz = model.size();
        if (p.splitEv && rdy) splitExp++;
        if (fl) begin
            model.delete();
        end else begin
            if (rdy) for (int k = 0; k < int'(p.deq); k++) void'(model.pop_front());
            if (e0v && (DEPTH - sz) >= 2) begin
                model.push_back('{inst: e0i, ctrl: e0c});
                if (e1v) model.push_back('{inst: e1i, ctrl: e1c});
            end
        end
        @(negedge clock_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) applyStimulus(0, '0, '0, 0, '0, '0, rdy, 0);
    endtask

    task automatic midReset();
        enq0_valid_i = 0; enq1_valid_i = 0; flush_i = 0; iss_ready_i = 1;
        #2 reset_ni = 1'b0;
        #1;
        chk("rst_iss0_valid", iss0_valid_o, 0);
        chk("rst_iss1_valid", iss1_valid_o, 0);
        chk("rst_iss0_inst", iss0_inst_o, 0);
        chk("rst_iss1_ctrl", iss1_ctrl_o, 0);
        chk("rst_iss_swap", iss_swap_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_enq_ready", enq_ready_o, 1);
        chk("rst_split_cnt", split_cnt_o, 0);
        model.delete();
        splitExp = 0;
        @(negedge clock_i);
        reset_ni = 1'b1;
    endtask

    localparam logic [31:0] ADD1 = 32'h003100B3;
    localparam logic [31:0] ADD2 = 32'h00628233;
    localparam logic [31:0] ADDI = 32'h00100293;
    localparam logic [31:0] ADD3 = 32'h00528333;

    initial begin
        logic [19:0] cA, cB;
        logic [31:0] wA, wB;
        reset_ni = 0; flush_i = 0; iss_ready_i = 0;
        enq0_valid_i = 0; enq1_valid_i = 0;
        enq0_inst_i = '0; enq1_inst_i = '0; enq0_ctrl_i = '0; enq1_ctrl_i = '0;
        repeat (2) @(negedge clock_i);
        checkOutput();
        chk("reset_enq_ready", enq_ready_o, 1);
        reset_ni = 1;

        // Independent unpinned pair issues straight in the following cycle.
        applyStimulus(1, ADD1, mkCtrl(1, 2, 3, 1, 1, 1, 0, 0), 1, ADD2, mkCtrl(4, 5, 6, 1, 1, 1, 0, 0), 1, 0);
        chk("pair_v0", iss0_valid_o, 1);
        chk("pair_v1", iss1_valid_o, 1);
        chk("pair_inst0", iss0_inst_o, ADD1);
        chk("pair_swap", iss_swap_o, 0);
        idle(1, 1);
        chk("pair_drained", count_o, 0);

        // RAW dependency on x5 splits the pair.
        applyStimulus(1, ADDI, mkCtrl(5, 0, 0, 1, 1, 0, 0, 0), 1, ADD3, mkCtrl(6, 5, 5, 1, 1, 1, 0, 0), 1, 0);
        chk("dep_first", iss0_inst_o, ADDI);
        chk("dep_first_v1", iss1_valid_o, 0);
        idle(1, 1);
        chk("dep_second", iss0_inst_o, ADD3);
        idle(1, 1);
`ifdef ISSUE_PERF_EN
        chk("dep_split_cnt", split_cnt_o, 1);
`else
        chk("dep_split_cnt", split_cnt_o, 0);
`endif

        // Older pinned to lane 1 forces a swapped pair.
        applyStimulus(1, ADD1, mkCtrl(1, 2, 3, 1, 1, 1, 1, 1), 1, ADD2, mkCtrl(4, 5, 6, 1, 1, 1, 0, 0), 1, 0);
        chk("swap_flag", iss_swap_o, 1);
        chk("swap_older_on_1", iss1_inst_o, ADD1);
        idle(1, 1);

        // Both pinned to lane 0: two single issues in order.
        applyStimulus(1, ADD1, mkCtrl(1, 2, 3, 1, 1, 1, 1, 0), 1, ADD2, mkCtrl(4, 5, 6, 1, 1, 1, 1, 0), 1, 0);
        chk("pin0_first", iss0_inst_o, ADD1);
        idle(1, 1);
        chk("pin0_second", iss0_inst_o, ADD2);
        idle(1, 1);

        // Fill to full with downstream stalled, then drain across the wrap point.
        for (int k = 0; k < 5; k++) begin
            wA = $urandom; wB = $urandom;
            applyStimulus(1, wA, mkCtrl(k + 1, 0, 0, 0, 0, 0, 0, 0), 1, wB, mkCtrl(k + 9, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        end
        chk("full_count", count_o, 8);
        chk("full_enq_ready", enq_ready_o, 0);
        idle(5, 1);

        // Flush with a same-cycle enqueue.
        for (int k = 0; k < 3; k++)
            applyStimulus(1, $urandom, mkCtrl(1, 0, 0, 0, 0, 0, 0, 0), 1, $urandom, mkCtrl(2, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        applyStimulus(1, ADD1, '0, 1, ADD2, '0, 1, 1);
        chk("flush_count", count_o, 0);
        chk("flush_v0", iss0_valid_o, 0);
        chk("flush_enq_ready", enq_ready_o, 1);

        // Reset while entries are buffered.
        applyStimulus(1, ADD1, '0, 1, ADD2, '0, 0, 0);
        applyStimulus(1, ADDI, '0, 0, '0, '0, 0, 0);
        midReset();
        idle(1, 1);

        // Randomized traffic with a small register space to provoke dependencies.
        for (int n = 0; n < 600; n++) begin
            cA = mkCtrl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            cB = mkCtrl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            applyStimulus($urandom_range(0, 3) != 0, $urandom, cA, $urandom_range(0, 1) == 1, $urandom, cB,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        idle(6, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order dual-issue queue that sits between decode and the register-file read stage.
- Buffers decoded instruction pairs, up to DEPTH entries.
- Each cycle, selects up to two of the oldest entries for issue and steers them onto lanes 0/1 according to the ctrl-bus slot-pinning fields.
- Splits a pair when the younger instruction depends on the older one.
- Unlike the fixed two-instruction steering used today, it decouples decode from issue stalls through buffering, handshakes on both sides, and supports flush.

## Interface
- DEPTH, 8, queue entries; power of two, ≥4.
- clock_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all entries.
- enq0_valid_i  in  1  older incoming instruction valid.
- enq1_valid_i  in  1  younger incoming instruction valid; ignored unless enq0_valid_i.
- enq0_inst_i / enq1_inst_i  in  32  instruction words.
- enq0_ctrl_i / enq1_ctrl_i  in  `CTRL_BUS  decoded control.
- enq_ready_o  out  1  at least two free entries.
- iss0_valid_o / iss1_valid_o  out  1  lane 0 / lane 1 carries an instruction this cycle.
- iss0_inst_o / iss1_inst_o  out  32  lane instructions; 0 when lane not valid.
- iss0_ctrl_o / iss1_ctrl_o  out  `CTRL_BUS  lane control; 0 when lane not valid.
- iss_swap_o  out  1  lane 1 holds the older instruction of the issued pair/single.
- iss_ready_i  in  1  downstream accepts; low means nothing dequeues.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- split_cnt_o  out  32  pair-split counter (see Configuration).

## Operation
- Storage: circular buffer of DEPTH entries {inst, ctrl}; head/tail pointers wrap modulo DEPTH; count tracked separately.
- Enqueue fires when enq0_valid_i && enq_ready_o. It writes enq0 at tail, and enq1 at tail+1 if enq1_valid_i. Tail and count advance by 1 or 2.
- H0 = entry at head (present if count ≥1); H1 = head+1 (present if count ≥2).
- dep: true when all of the following hold:
  - H0 REGWRITE is set and H0 RD ≠ 0;
  - either (H1 RS1 == H0 RD and H1 RS1_ACTIVE) or (H1 RS2 == H0 RD and H1 RS2_ACTIVE).
- Pinning: entry pinned to lane s when ISSUE_PRI = 1 and ISSUE_SLOT = s.
- conflict: H0 and H1 are both pinned to the same lane.
- pair = H1 present && !dep && !conflict.
- Pair lane assignment: swap (H0→lane1, H1→lane0) when H0 is pinned to lane 1 or H1 is pinned to lane 0; otherwise straight.
- Single issue (H1 absent, dep, or conflict): H0 goes to lane 1 if pinned to lane 1, else lane 0. The other lane is invalid; iss_swap_o = 1 only when H0 is on lane 1.
- Dequeue of 1 or 2 entries occurs when iss_ready_i = 1 and at least one lane is valid.
- Program order is preserved; an entry never issues ahead of an older one.

## Timing
- All issue outputs are combinational from registered queue state plus iss_ready_i-independent logic; iss_ready_i gates only the dequeue.
- enq_ready_o is derived from registered count only (DEPTH − count ≥ 2); there is no enq→ready combinational path.
- Enqueue-to-issue latency: 1 cycle minimum (written at edge N, visible on issue lanes in cycle N+1).
- Simultaneous enqueue and dequeue: count_next = count + enq_n − deq_n. Legal at full−2 and at empty.
- Empty: both lanes invalid, outputs 0.
- Full: enq_ready_o = 0 whenever count > DEPTH−2.
- Flush: next edge sets head = tail = count = 0. It overrides a same-cycle enqueue/dequeue; issue outputs in the flush cycle are still driven but are discarded by downstream.
- Reset (async assert, synchronous deassert handled upstream): pointers, count, split_cnt_o = 0; storage contents don't-care; all outputs 0 except enq_ready_o = 1.
- Reset mid-operation discards all entries immediately.

## Configuration
- ISSUE_PERF_EN defined: split_cnt_o increments (wrapping mod 2^32) on every cycle where H1 is present, iss_ready_i = 1, and the pair is split by dep or conflict. Cleared by reset only, not by flush.
- Not defined: split_cnt_o is tied to 0 and no counter register exists.

## Test plan
- Reset, then enqueue ADD x1,x2,x3 / ADD x4,x5,x6 (no pins), iss_ready_i = 1 → next cycle both lanes valid straight, iss_swap_o = 0, count_o returns to 0.
- Enqueue ADDI x5,x0,1 then ADD x6,x5,x5 → cycle 1: lane0 issues ADDI only; cycle 2: lane0 issues ADD; split_cnt_o = 1 with ISSUE_PERF_EN, 0 without.
- Older pinned lane1 (ISSUE_PRI = 1, ISSUE_SLOT = 1), younger unpinned, independent → pair swapped, iss_swap_o = 1, older on iss1.
- Both pinned lane0 → two single-issue cycles on lane0, in order.
- Hold iss_ready_i = 0 and push 4 pairs with DEPTH = 8 → count_o = 8, enq_ready_o = 0 from count 7 onward. Release → drains 2 per cycle, pointers wrap, data intact.
- Fill 6 entries, assert flush_i together with enq0/enq1 valid → next cycle count_o = 0, lanes invalid, enq_ready_o = 1; assert reset_ni low mid-stream → outputs 0 asynchronously.
